// File: rtl/ldunit.sv
// ldunit: sequential load unit. Accepts a load request (byte address +
// RISC-V funct3), issues one or two aligned word reads on the data-memory
// port, extracts and sign/zero-extends the addressed byte/half/word/double
// and returns the result over a valid/ready handshake.
//
// Build option: LDUNIT_MISALIGN_EN
//   defined   - word-crossing loads are split into two reads (RD0 + RD1)
//   undefined - word-crossing loads complete immediately with out_err=10
//
// Ports:
//   clock, reset           rising-edge clock, async active-high reset
//   req_valid/req_ready    request handshake (ready only when idle)
//   req_addr, req_funct3   byte address and load type
//   mem_rd, mem_addr       word read request, held until mem_ack
//   mem_ack, mem_rdata     read data valid / read data
//   out_valid/out_ready    result handshake
//   out_data, out_err      extended load data; 00 ok, 01 illegal, 10 misaligned
module ldunit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_addr,
  input  logic [2:0]      req_funct3,
  output logic            mem_rd,
  output logic [31:0]     mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [1:0]      out_err
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_ILL = 2'b01;
`ifndef LDUNIT_MISALIGN_EN
  localparam logic [1:0] ERR_MIS = 2'b10;
`endif

`ifdef LDUNIT_MISALIGN_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RD0 = 2'd1, RD1 = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RD0 = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t          state, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [2:0]      f3_q, f3_d;
`ifdef LDUNIT_MISALIGN_EN
  logic [XLEN-1:0] w0_q, w0_d;
`endif
  logic            req_ready_d, mem_rd_d, out_valid_d;
  logic [31:0]     mem_addr_d, base_d;
  logic [XLEN-1:0] data_d;
  logic [1:0]      err_d;

  // funct3 codes that name a load supported at this XLEN
  function automatic logic is_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
      3'b011, 3'b110:                         ok = (XLEN == 64);
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // access runs past the end of its word
  function automatic logic crosses(input logic [OW-1:0] off, input logic [2:0] f3);
    logic [4:0] size;
    case (f3[1:0])
      2'b00:   size = 5'd1;
      2'b01:   size = 5'd2;
      2'b10:   size = 5'd4;
      default: size = 5'd8;
    endcase
    return (5'(off) + size) > 5'(NB);
  endfunction

  // shift the {hi,lo} word pair down to the addressed byte, then extend
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] hi,
                                              input logic [XLEN-1:0] lo,
                                              input logic [OW-1:0]   off,
                                              input logic [2:0]      f3);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = XLEN'({hi, lo} >> {off, 3'b000});
    case (f3)
      3'b000:  res = XLEN'($signed(sh[7:0]));
      3'b001:  res = XLEN'($signed(sh[15:0]));
      3'b010:  res = XLEN'($signed(sh[31:0]));
      3'b100:  res = XLEN'(sh[7:0]);
      3'b101:  res = XLEN'(sh[15:0]);
      3'b110:  res = XLEN'(sh[31:0]);
      3'b011:  res = sh;
      default: res = '0;
    endcase
    return res;
  endfunction

  // next-state and next-output logic
  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    f3_d    = f3_q;
`ifdef LDUNIT_MISALIGN_EN
    w0_d    = w0_q;
`endif
    data_d  = out_data;
    err_d   = out_err;

    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          f3_d   = req_funct3;
          if (!is_legal(req_funct3)) begin
            state_d = DONE;
            data_d  = '0;
            err_d   = ERR_ILL;
          end
`ifndef LDUNIT_MISALIGN_EN
          else if (crosses(req_addr[OW-1:0], req_funct3)) begin
            state_d = DONE;
            data_d  = '0;
            err_d   = ERR_MIS;
          end
`endif
          else begin
            state_d = RD0;
          end
        end
      end
      RD0: begin
        if (mem_ack) begin
`ifdef LDUNIT_MISALIGN_EN
          if (crosses(addr_q[OW-1:0], f3_q)) begin
            w0_d    = mem_rdata;
            state_d = RD1;
          end else
`endif
          begin
            data_d  = extract('0, mem_rdata, addr_q[OW-1:0], f3_q);
            err_d   = ERR_OK;
            state_d = DONE;
          end
        end
      end
`ifdef LDUNIT_MISALIGN_EN
      RD1: begin
        if (mem_ack) begin
          data_d  = extract(mem_rdata, w0_q, addr_q[OW-1:0], f3_q);
          err_d   = ERR_OK;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // registered handshake/memory outputs follow the next state
    base_d      = {addr_d[31:OW], {OW{1'b0}}};
    req_ready_d = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    mem_rd_d    = (state_d == RD0);
    mem_addr_d  = mem_addr;
    if (state_d == RD0) mem_addr_d = base_d;
`ifdef LDUNIT_MISALIGN_EN
    if (state_d == RD1) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = base_d + 32'(NB);
    end
`endif
  end

  // state and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      f3_q      <= '0;
`ifdef LDUNIT_MISALIGN_EN
      w0_q      <= '0;
`endif
      req_ready <= 1'b1;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= ERR_OK;
    end else begin
      state     <= state_d;
      addr_q    <= addr_d;
      f3_q      <= f3_d;
`ifdef LDUNIT_MISALIGN_EN
      w0_q      <= w0_d;
`endif
      req_ready <= req_ready_d;
      mem_rd    <= mem_rd_d;
      mem_addr  <= mem_addr_d;
      out_valid <= out_valid_d;
      out_data  <= data_d;
      out_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_ldunit.sv
// Bench for ldunit: a 32-bit and a 64-bit instance, a byte-addressed memory
// model with configurable ack wait states, and a reference load model that
// gathers bytes little-endian from memory and extends them.
module tb_ldunit;

  logic        clock, reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        mem_rd, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_err;

  logic        req_valid64, req_ready64;
  logic [31:0] req_addr64;
  logic [2:0]  req_funct364;
  logic        mem_rd64, mem_ack64;
  logic [31:0] mem_addr64;
  logic [63:0] mem_rdata64;
  logic        out_valid64, out_ready64;
  logic [63:0] out_data64;
  logic [1:0]  out_err64;

  ldunit #(.XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_funct3(req_funct3),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  ldunit #(.XLEN(64)) dut64 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_addr(req_addr64), .req_funct3(req_funct364),
    .mem_rd(mem_rd64), .mem_addr(mem_addr64), .mem_ack(mem_ack64), .mem_rdata(mem_rdata64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64), .out_err(out_err64)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  err;
    int          nacc;
    logic [31:0] a0;
    logic [31:0] a1;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp64_q[$];
  logic [31:0] got_q[$];
  logic [31:0] got64_q[$];
  bit   [7:0]  mem_b [bit [31:0]];

  int          n_cmp = 0, n_fail = 0;
  int          neg_cnt = 0, acc_cnt = 0;
  bit          inflight = 0, first_v = 0;
  int          wait_cfg = 0, cnt = 0;
  logic [31:0] held;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mb(input logic [31:0] a);
    return mem_b.exists(a) ? mem_b[a] : 8'h00;
  endfunction

  task automatic set_w32(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem_b[a + 32'(i)] = w[8*i +: 8];
  endtask

  function automatic logic [31:0] word32(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mb(a + 32'(i));
    return w;
  endfunction

  function automatic logic [63:0] word64(input logic [31:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = mb(a + 32'(i));
    return w;
  endfunction

  // reference load: legality, crossing, byte gather, extension
  function automatic void model(input int xlen, input logic [31:0] addr,
                                input logic [2:0] f3, output exp_t e);
    int nb, size, off;
    bit legal, mis;
    logic [63:0] v;
    nb = xlen / 8;
    e.data = '0; e.err = 2'b00; e.nacc = 0; e.a0 = '0; e.a1 = '0; e.lat = 1;
    legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
            (xlen == 64 && (f3 == 3'b011 || f3 == 3'b110));
    if (!legal) begin e.err = 2'b01; return; end
    size = 1 << f3[1:0];
    off  = int'(addr % 32'(nb));
    mis  = (off + size) > nb;
`ifndef LDUNIT_MISALIGN_EN
    if (mis) begin e.err = 2'b10; return; end
`endif
    e.a0   = addr - 32'(off);
    e.a1   = e.a0 + 32'(nb);
    e.nacc = mis ? 2 : 1;
    v = '0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = mb(addr + 32'(i));
    if (!f3[2] && size * 8 < xlen && v[size*8-1]) v = v | ~((64'd1 << (size * 8)) - 64'd1);
    if (xlen == 32) v[63:32] = '0;
    e.data = v;
  endfunction

  task automatic chk_acc(input string nm, input exp_t e, input logic [31:0] got[$]);
    chk({nm, " read count"}, 64'(got.size()), 64'(e.nacc));
    if (e.nacc > 0 && got.size() > 0) chk({nm, " addr0"}, 64'(got[0]), 64'(e.a0));
    if (e.nacc > 1 && got.size() > 1) chk({nm, " addr1"}, 64'(got[1]), 64'(e.a1));
  endtask

  // memory responders: ack after wait_cfg idle cycles (32-bit), immediately (64-bit)
  always @(negedge clock) begin
    if (reset) begin
      mem_ack = 1'b0; cnt = 0;
    end else begin
      if (mem_ack) begin mem_ack = 1'b0; cnt = 0; end
      if (mem_rd) begin
        if (cnt == 0) held = mem_addr;
        else chk("mem_addr stable", 64'(mem_addr), 64'(held));
        if (cnt >= wait_cfg) begin
          mem_ack   = 1'b1;
          mem_rdata = word32(mem_addr);
          got_q.push_back(mem_addr);
        end else cnt++;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) mem_ack64 = 1'b0;
    else begin
      if (mem_ack64) mem_ack64 = 1'b0;
      if (mem_rd64) begin
        mem_ack64   = 1'b1;
        mem_rdata64 = word64(mem_addr64);
        got64_q.push_back(mem_addr64);
      end
    end
  end

  // output compare against the expectation queues
  always @(negedge clock) begin
    neg_cnt++;
    if (!reset) begin
      chk("req_ready", 64'(req_ready), 64'(!inflight));
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious out_valid", 64'(out_valid), 64'(0));
        else begin
          if (first_v) begin
            chk("latency", 64'(neg_cnt - acc_cnt), 64'(exp_q[0].lat));
            first_v = 0;
          end
          chk("out_data", 64'(out_data), exp_q[0].data);
          chk("out_err", 64'(out_err), 64'(exp_q[0].err));
          if (out_ready) begin
            chk_acc("x32", exp_q[0], got_q);
            got_q.delete();
            void'(exp_q.pop_front());
            inflight = 0;
          end
        end
      end
      if (out_valid64) begin
        if (exp64_q.size() == 0) chk("spurious out_valid64", 64'(out_valid64), 64'(0));
        else begin
          chk("out_data64", out_data64, exp64_q[0].data);
          chk("out_err64", 64'(out_err64), 64'(exp64_q[0].err));
          if (out_ready64) begin
            chk_acc("x64", exp64_q[0], got64_q);
            got64_q.delete();
            void'(exp64_q.pop_front());
          end
        end
      end
    end
  end

  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input int waits,
                         input int hold, input logic [31:0] lit, input logic [1:0] lit_err);
    exp_t e;
    model(32, addr, f3, e);
    chk("model pin data", e.data, 64'(lit));
    chk("model pin err", 64'(e.err), 64'(lit_err));
    e.lat = (e.err != 2'b00) ? 1 : ((e.nacc == 1) ? 2 + waits : 3 + 2 * waits);
    wait_cfg  = waits;
    out_ready = (hold == 0);
    for (int i = 0; i < 40 && !req_ready; i++) begin @(posedge clock); #1; end
    exp_q.push_back(e);
    req_valid = 1'b1; req_addr = addr; req_funct3 = f3;
    @(posedge clock); #1;
    req_valid = 1'b0; inflight = 1; first_v = 1; acc_cnt = neg_cnt;
    if (hold > 0) begin
      for (int i = 0; i < 60 && !out_valid; i++) begin @(posedge clock); #1; end
      repeat (hold) begin @(posedge clock); #1; end
      out_ready = 1'b1;
    end
    for (int i = 0; i < 80 && inflight; i++) begin @(posedge clock); #1; end
    if (inflight) begin
      n_cmp++; n_fail++;
      $display("FAIL load timeout addr=%h funct3=%b: no result handshake", addr, f3);
      exp_q.delete(); got_q.delete(); inflight = 0;
    end
    out_ready = 1'b1;
  endtask

  task automatic do_load64(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [63:0] lit, input logic [1:0] lit_err);
    exp_t e;
    model(64, addr, f3, e);
    chk("model64 pin data", e.data, lit);
    chk("model64 pin err", 64'(e.err), 64'(lit_err));
    for (int i = 0; i < 40 && !req_ready64; i++) begin @(posedge clock); #1; end
    exp64_q.push_back(e);
    req_valid64 = 1'b1; req_addr64 = addr; req_funct364 = f3;
    @(posedge clock); #1;
    req_valid64 = 1'b0;
    for (int i = 0; i < 40 && exp64_q.size() != 0; i++) begin @(posedge clock); #1; end
    if (exp64_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL load64 timeout addr=%h funct3=%b: no result", addr, f3);
      exp64_q.delete(); got64_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] tgt;
    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_funct3 = '0; out_ready = 1'b1;
    req_valid64 = 1'b0; req_addr64 = '0; req_funct364 = '0; out_ready64 = 1'b1;
    mem_ack = 1'b0; mem_rdata = '0; mem_ack64 = 1'b0; mem_rdata64 = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst req_ready", 64'(req_ready), 64'(1));
    chk("rst mem_rd", 64'(mem_rd), 64'(0));
    chk("rst mem_addr", 64'(mem_addr), 64'(0));
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst out_data", 64'(out_data), 64'(0));
    chk("rst out_err", 64'(out_err), 64'(0));
    chk("rst req_ready64", 64'(req_ready64), 64'(1));
    chk("rst out_data64", out_data64, 64'(0));
    reset = 1'b0;

    set_w32(32'h0000_1000, 32'h8012_3456);
    do_load(32'h0000_1003, 3'b000, 0, 0, 32'hFFFF_FF80, 2'b00);
    do_load(32'h0000_1002, 3'b101, 0, 0, 32'h0000_8012, 2'b00);
    do_load(32'h0000_1000, 3'b001, 0, 0, 32'h0000_3456, 2'b00);
    do_load(32'h0000_1001, 3'b100, 1, 0, 32'h0000_0034, 2'b00);
    do_load(32'h0000_1000, 3'b010, 0, 0, 32'h8012_3456, 2'b00);

    set_w32(32'h0000_1000, 32'hDDCC_BBAA);
    set_w32(32'h0000_1004, 32'h4433_2211);
`ifdef LDUNIT_MISALIGN_EN
    do_load(32'h0000_1002, 3'b010, 0, 0, 32'h2211_DDCC, 2'b00);
    do_load(32'h0000_1003, 3'b001, 1, 0, 32'h0000_11DD, 2'b00);
`else
    do_load(32'h0000_1002, 3'b010, 0, 0, 32'h0000_0000, 2'b10);
    do_load(32'h0000_1003, 3'b001, 1, 0, 32'h0000_0000, 2'b10);
`endif
    do_load(32'h0000_1000, 3'b011, 0, 0, 32'h0, 2'b01);
    do_load(32'h0000_1000, 3'b111, 0, 0, 32'h0, 2'b01);
    do_load(32'h0000_1000, 3'b110, 0, 2, 32'h0, 2'b01);
    do_load(32'h0000_1004, 3'b010, 3, 5, 32'h4433_2211, 2'b00);
    do_load(32'h0000_1001, 3'b101, 0, 2, 32'h0000_CCBB, 2'b00);
    do_load(32'h0000_1001, 3'b001, 2, 0, 32'hFFFF_CCBB, 2'b00);

    set_w32(32'hFFFF_FFFC, 32'h1234_5678);
    set_w32(32'h0000_0000, 32'h9ABC_DEF0);
`ifdef LDUNIT_MISALIGN_EN
    do_load(32'hFFFF_FFFE, 3'b010, 1, 0, 32'hDEF0_1234, 2'b00);
    tgt = 32'h0000_1004;
    req_addr = 32'h0000_1002;
`else
    do_load(32'hFFFF_FFFE, 3'b010, 1, 0, 32'h0, 2'b10);
    tgt = 32'h0000_1000;
    req_addr = 32'h0000_1000;
`endif

    // abandon a load mid-read with an asynchronous reset
    wait_cfg = 20;
    for (int i = 0; i < 40 && !req_ready; i++) begin @(posedge clock); #1; end
    req_valid = 1'b1; req_funct3 = 3'b010;
    @(posedge clock); #1;
    req_valid = 1'b0; inflight = 1;
    for (int i = 0; i < 60 && !(mem_rd && mem_addr == tgt); i++) begin @(posedge clock); #1; end
    chk("reached read before reset", 64'(mem_rd && mem_addr == tgt), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("async rst mem_rd", 64'(mem_rd), 64'(0));
    chk("async rst out_valid", 64'(out_valid), 64'(0));
    chk("async rst req_ready", 64'(req_ready), 64'(1));
    inflight = 0; got_q.delete(); wait_cfg = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    do_load(32'h0000_1000, 3'b010, 0, 0, 32'hDDCC_BBAA, 2'b00);

    set_w32(32'h0000_2000, 32'h1122_3344);
    set_w32(32'h0000_2004, 32'h8000_0001);
    do_load64(32'h0000_2004, 3'b110, 64'h0000_0000_8000_0001, 2'b00);
    do_load64(32'h0000_2004, 3'b010, 64'hFFFF_FFFF_8000_0001, 2'b00);
    do_load64(32'h0000_2000, 3'b011, 64'h8000_0001_1122_3344, 2'b00);
    do_load64(32'h0000_2007, 3'b000, 64'hFFFF_FFFF_FFFF_FF80, 2'b00);
    do_load64(32'h0000_2006, 3'b101, 64'h0000_0000_0000_8000, 2'b00);
    do_load64(32'h0000_2000, 3'b111, 64'h0, 2'b01);
`ifdef LDUNIT_MISALIGN_EN
    do_load64(32'h0000_2006, 3'b010, 64'h0000_0000_0000_8000, 2'b00);
`else
    do_load64(32'h0000_2006, 3'b010, 64'h0, 2'b10);
`endif

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ldunit.md
Name: ldunit

Overview:
- Parametrised, sequential successor to the combinational load-data converter.
- Accepts a load request (byte address, funct3) from the control unit and issues one or two aligned word reads on the data-memory port.
- Extracts and sign/zero-extends the addressed byte, half, word or (XLEN=64) double, and returns the result with a valid/ready handshake.
- Sits between the datapath's load path and data memory. Replaces the converter on multi-cycle load paths.

Parameters:
XLEN  32  data/word width in bits; legal values 32 or 64; address width fixed at 32
NB    XLEN/8  byte lanes per word (derived; not overridable)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
req_valid  in  1  load request present
req_ready  out  1  unit accepts request (high only in IDLE)
req_addr  in  32  byte address
req_funct3  in  3  load type, RISC-V funct3 encoding
mem_rd  out  1  memory read request, held until mem_ack
mem_addr  out  32  word-aligned read address (low log2(NB) bits zero)
mem_ack  in  1  read data valid this cycle
mem_rdata  in  XLEN  read data
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_data  out  XLEN  converted load data
out_err  out  2  00 ok, 01 illegal funct3, 10 misaligned (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high. clock is the single clock.
- On reset assertion, state=IDLE immediately. Reset values: req_ready=1, mem_rd=0, mem_addr=0, out_valid=0, out_data=0, out_err=00.
- Reset mid-transaction abandons the transaction; mem_rd drops without waiting for mem_ack.
- funct3 decode:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - XLEN=64 only: 011 LD, 110 LWU.
  - All other codes are illegal: 111 always; 011 and 110 when XLEN=32.
- Size S in bytes = 1/2/4/8. offset = req_addr mod NB.
- A request is misaligned when offset+S > NB, i.e. it crosses a word boundary. Naturally unaligned accesses that stay inside one word (e.g. LH at offset 1) are single-word accesses.
- States:
  - IDLE:
    - req_valid=1 latches addr/funct3 on the clock edge.
    - Illegal funct3 -> DONE with out_err=01, out_data=0, no memory access.
    - Otherwise -> RD0.
  - RD0:
    - mem_rd=1, mem_addr=addr with low bits cleared.
    - On mem_ack, capture w0.
    - Misaligned -> RD1; else -> DONE.
  - RD1:
    - mem_rd=1, mem_addr=aligned addr + NB, wrapping modulo 2^32.
    - On mem_ack, capture w1 -> DONE.
  - DONE:
    - out_valid=1; out_data and out_err stable.
    - out_ready=1 -> IDLE; out_valid falls the next cycle.
- mem_rd deasserts in the cycle after mem_ack. mem_rd and mem_addr do not change while mem_rd=1 and mem_ack=0.
- Extraction:
  - raw = ({w1,w0} >> offset*8) truncated to S bytes; w1 is 0 for single-word accesses.
  - Sign-extend for LB/LH/LW (LW only when XLEN=64); zero-extend for LBU/LHU/LWU. LW at XLEN=32 and LD pass through.
- Latency:
  - Aligned load with mem_ack in the first RD0 cycle: request accepted at edge 0, mem_rd high in cycle 1, out_valid high in cycle 2.
  - Each additional mem_ack wait cycle adds 1 cycle. A split load adds the RD1 phase.
- No new request is accepted until DONE exits; req_ready=0 in RD0, RD1 and DONE.
- out_valid may be held indefinitely by out_ready=0.
- mem_ack outside RD0/RD1 is ignored.

Optional Feature:
- Macro: LDUNIT_MISALIGN_EN.
- Defined: misaligned requests are split into RD0+RD1 as above; out_err=10 never occurs.
- Not defined:
  - RD1 is not built.
  - A misaligned request goes IDLE -> DONE with out_err=10, out_data=0 and no memory access.
  - Aligned behaviour is identical to the defined case.

Test Plan:
- XLEN=32, LB, addr 0x0000_1003, mem word 0x8012_3456 -> mem_addr 0x0000_1000, out_data 0xFFFF_FF80, out_err 00; out_valid 2 cycles after accept with 0-wait mem_ack.
- XLEN=32, LHU, addr 0x0000_1002, same word -> out_data 0x0000_8012. Then LH at addr 0x0000_1000 -> 0x0000_3456.
- With LDUNIT_MISALIGN_EN, XLEN=32, LW, addr 0x0000_1002:
  - words 0xDDCC_BBAA @0x1000 and 0x4433_2211 @0x1004.
  - Expect two mem_rd transactions at 0x1000 then 0x1004, out_data 0x2211_DDCC.
  - Without the macro -> out_err 10, no mem_rd.
- XLEN=32, funct3 011 -> out_err 01, out_data 0, mem_rd never asserted. XLEN=64, LWU of 0x8000_0001 at offset 4 -> out_data 0x0000_0000_8000_0001.
- Backpressure and wait states: mem_ack delayed 3 cycles -> mem_addr stable throughout; out_ready low 5 cycles -> out_valid and out_data held, req_ready stays 0.
- Reset asserted asynchronously mid-RD1 -> mem_rd, out_valid 0 immediately, req_ready 1. A following aligned LW completes normally.
